// File: rtl/blit_arb_pkg.sv
// Shared types and defaults for the blitter SDRAM arbiter.
// Used by blit_sdram_arbiter and blit_arb_burst_tracker.
package blit_arb_pkg;

  localparam int BLIT_ADDR_W = 26;

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_CMD, RD_DATA} arb_state_t;
  typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

  // Round-robin pick; callers only use it when at least one side requests.
  function automatic grant_t pick_grant(input logic rd_req, input logic wr_req,
                                        input grant_t last_grant);
    if (rd_req && wr_req) return (last_grant == GRANT_WRITE) ? GRANT_READ : GRANT_WRITE;
    return rd_req ? GRANT_READ : GRANT_WRITE;
  endfunction

endpackage

// File: rtl/blit_arb_burst_tracker.sv
// Read-burst word tracker: counts returned words, tags each with its byte
// address, and flags the last word of the burst.
module blit_arb_burst_tracker
  import blit_arb_pkg::*;
#(
  parameter int ADDR_W    = BLIT_ADDR_W,
  parameter int BURST_LEN = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              active,
  input  logic [ADDR_W-1:0] base,
  input  logic              sdram_rvalid,
  input  logic [31:0]       sdram_rdata,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] raddress,
  output logic              complete,
  output logic              done
);

  localparam int CNT_W = $clog2(BURST_LEN);

  logic [CNT_W-1:0] count;
  logic             take;
  logic             last_word;

  // Words arriving outside an active burst are dropped without touching the count.
  assign take      = active && sdram_rvalid;
  assign last_word = (count == CNT_W'(BURST_LEN - 1));
  assign done      = take && last_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      raddress <= '0;
      complete <= 1'b0;
    end else begin
      rvalid   <= take;
      complete <= done;
      if (take) begin
        count    <= last_word ? '0 : count + CNT_W'(1);
        rdata    <= sdram_rdata;
        raddress <= base + ADDR_W'({count, 2'b00});
      end
    end
  end

endmodule

// File: rtl/blit_sdram_arbiter.sv
// Round-robin arbiter of the blitter read/write ports onto one SDRAM port.
// Optional performance counters are built when BLIT_ARB_PERF_EN is defined.
//
// state   | meaning
// IDLE    | no command in flight; arbitrate pending requests
// RD_CMD  | read burst command presented, waiting for sdram_ready
// WR_CMD  | write command presented, waiting for sdram_ready
// RD_DATA | collecting BURST_LEN read words; no new grants
module blit_sdram_arbiter
  import blit_arb_pkg::*;
#(
  parameter int ADDR_W    = BLIT_ADDR_W,
  parameter int BURST_LEN = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              blitr_sdram_request,
  input  logic [ADDR_W-1:0] blitr_sdram_address,
  output logic              blitr_sdram_ready,
  output logic              blitr_sdram_rvalid,
  output logic [31:0]       blitr_sdram_rdata,
  output logic [ADDR_W-1:0] blitr_sdram_raddress,
  output logic              blitr_sdram_complete,
  input  logic              blitw_sdram_request,
  input  logic [ADDR_W-1:0] blitw_sdram_address,
  input  logic [3:0]        blitw_sdram_wstrb,
  input  logic [31:0]       blitw_sdram_wdata,
  output logic              blitw_sdram_ready,
  output logic              sdram_request,
  output logic              sdram_write,
  output logic [ADDR_W-1:0] sdram_address,
  output logic [3:0]        sdram_wstrb,
  output logic [31:0]       sdram_wdata,
  input  logic              sdram_ready,
  input  logic              sdram_rvalid,
  input  logic [31:0]       sdram_rdata,
  output logic [31:0]       perf_read_bursts,
  output logic [31:0]       perf_write_words
);

  localparam logic [ADDR_W-1:0] BURST_MASK = ~ADDR_W'(BURST_LEN * 4 - 1);

  arb_state_t        state, state_nx;
  grant_t            last_grant, grant_nx;
  logic              capture;
  logic              burst_done;
  logic              in_burst;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_WRITE;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        last_grant <= grant_nx;
        if (grant_nx == GRANT_READ) begin
          addr_q  <= blitr_sdram_address & BURST_MASK;
          wstrb_q <= '0;
          wdata_q <= '0;
        end else begin
          addr_q  <= blitw_sdram_address;
          wstrb_q <= blitw_sdram_wstrb;
          wdata_q <= blitw_sdram_wdata;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = last_grant;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (blitr_sdram_request || blitw_sdram_request) begin
          capture  = 1'b1;
          grant_nx = pick_grant(blitr_sdram_request, blitw_sdram_request, last_grant);
          state_nx = (grant_nx == GRANT_READ) ? RD_CMD : WR_CMD;
        end
      end
      RD_CMD:  if (sdram_ready) state_nx = RD_DATA;
      WR_CMD:  if (sdram_ready) state_nx = IDLE;
      RD_DATA: if (burst_done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sdram_request     = (state == RD_CMD) || (state == WR_CMD);
  assign sdram_write       = (state == WR_CMD);
  assign sdram_address     = addr_q;
  assign sdram_wstrb       = wstrb_q;
  assign sdram_wdata       = wdata_q;
  assign blitr_sdram_ready = (state == RD_CMD) && sdram_ready;
  assign blitw_sdram_ready = (state == WR_CMD) && sdram_ready;
  assign in_burst          = (state == RD_DATA);

  blit_arb_burst_tracker #(
    .ADDR_W   (ADDR_W),
    .BURST_LEN(BURST_LEN)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .active      (in_burst),
    .base        (addr_q),
    .sdram_rvalid(sdram_rvalid),
    .sdram_rdata (sdram_rdata),
    .rvalid      (blitr_sdram_rvalid),
    .rdata       (blitr_sdram_rdata),
    .raddress    (blitr_sdram_raddress),
    .complete    (blitr_sdram_complete),
    .done        (burst_done)
  );

`ifdef BLIT_ARB_PERF_EN
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      if (blitr_sdram_ready) perf_rd_q <= perf_rd_q + 32'd1;
      if (blitw_sdram_ready) perf_wr_q <= perf_wr_q + 32'd1;
    end
  end

  assign perf_read_bursts = perf_rd_q;
  assign perf_write_words = perf_wr_q;
`else
  assign perf_read_bursts = '0;
  assign perf_write_words = '0;
`endif

endmodule
